// File: rtl/writeback_regfile_if.sv
// Writeback-stage bundle: MEM/WB slot inputs, register read ports and writeback observation outputs.
// The master drives the slot and read addresses; the slave (the register file) answers.
interface writeback_regfile_if;
  logic        stall_disable;
  logic        flush;
  logic        regWriteEnable_MEMWB;
  logic [31:0] instruction_MEMWB;
  logic [31:0] PC_MEMWB;
  logic [31:0] execute_rst_MEMWB;
  logic        memRead_MEMWB;
  logic [31:0] memReadRst_MEMWB;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] retired_count;

  modport master (
    output stall_disable, flush, regWriteEnable_MEMWB, instruction_MEMWB, PC_MEMWB,
           execute_rst_MEMWB, memRead_MEMWB, memReadRst_MEMWB, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_we, wb_rd, wb_data, wb_pc, retired_count
  );

  modport slave (
    input  stall_disable, flush, regWriteEnable_MEMWB, instruction_MEMWB, PC_MEMWB,
           execute_rst_MEMWB, memRead_MEMWB, memReadRst_MEMWB, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_we, wb_rd, wb_data, wb_pc, retired_count
  );
endinterface

// File: rtl/writeback_regfile.sv
// RISC-V writeback stage: load extension, 31x32 register file with write-through reads,
// and a retired-instruction counter.
module writeback_regfile (
  input  logic               clk,
  input  logic               rst_n,
  writeback_regfile_if.slave bus
);
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        retire;

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] count_q, count_d;
  logic [31:0] rs1_val, rs2_val;

  // NOTE: every variable written here gets a default first, so no path leaves one holding (no latch).
  always_comb begin
    rd      = bus.instruction_MEMWB[11:7];
    funct3  = bus.instruction_MEMWB[14:12];
    off     = bus.execute_rst_MEMWB[1:0];
    ld_byte = bus.memReadRst_MEMWB[7:0];
    case (off)
      2'd1:    ld_byte = bus.memReadRst_MEMWB[15:8];
      2'd2:    ld_byte = bus.memReadRst_MEMWB[23:16];
      2'd3:    ld_byte = bus.memReadRst_MEMWB[31:24];
      default: ld_byte = bus.memReadRst_MEMWB[7:0];
    endcase
    // Halves ignore addr[0]: a misaligned half still picks the half selected by addr[1].
    ld_half = off[1] ? bus.memReadRst_MEMWB[31:16] : bus.memReadRst_MEMWB[15:0];
    case (funct3)
      F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_val = {24'h0, ld_byte};
      F3_LHU:  ld_val = {16'h0, ld_half};
      default: ld_val = bus.memReadRst_MEMWB;
    endcase
    wb_data = bus.memRead_MEMWB ? ld_val : bus.execute_rst_MEMWB;
    wb_we   = bus.regWriteEnable_MEMWB & bus.stall_disable & ~bus.flush & (rd != 5'd0);
    retire  = bus.stall_disable & ~bus.flush & (bus.instruction_MEMWB != 32'h0);
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (wb_we && rd == 5'(i)) regs_d[i] = wb_data;
    end
    count_d = count_q + {31'h0, retire};
  end

  // NOTE: the register array is reset like any other state, since software may read it before writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // x0 is never stored; the bypass covers a write landing on the addressed register this cycle.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.rs1_addr == 5'(i)) rs1_val = regs_q[i];
      if (bus.rs2_addr == 5'(i)) rs2_val = regs_q[i];
    end
    if (wb_we && bus.rs1_addr == rd) rs1_val = wb_data;
    if (wb_we && bus.rs2_addr == rd) rs2_val = wb_data;
  end

  assign bus.rs1_data      = rs1_val;
  assign bus.rs2_data      = rs2_val;
  assign bus.wb_we         = wb_we;
  assign bus.wb_rd         = rd;
  assign bus.wb_data       = wb_data;
  assign bus.wb_pc         = bus.PC_MEMWB;
  assign bus.retired_count = count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: expectations are queued as stimulus is driven
// and popped when the corresponding output is sampled.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_regfile_if bus ();
  writeback_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rf [32];
  logic [31:0] model_count;

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] mem);
    logic [31:0] b, h;
    b = mem >> {off, 3'b000};
    h = off[1] ? (mem >> 16) : mem;
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b101:  return {16'h0, h[15:0]};
      default: return mem;
    endcase
  endfunction

  function automatic logic model_we();
    return bus.regWriteEnable_MEMWB && bus.stall_disable && !bus.flush &&
           (bus.instruction_MEMWB[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] model_wdata();
    return bus.memRead_MEMWB ? load_model(bus.instruction_MEMWB[14:12],
                                          bus.execute_rst_MEMWB[1:0], bus.memReadRst_MEMWB)
                             : bus.execute_rst_MEMWB;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (model_we() && a == bus.instruction_MEMWB[11:7]) return model_wdata();
    return model_rf[a];
  endfunction

  task automatic drive(input logic we, input logic [31:0] instr, input logic [31:0] alu,
                       input logic memrd, input logic [31:0] mem);
    bus.regWriteEnable_MEMWB = we;
    bus.instruction_MEMWB    = instr;
    bus.execute_rst_MEMWB    = alu;
    bus.memRead_MEMWB        = memrd;
    bus.memReadRst_MEMWB     = mem;
    bus.PC_MEMWB             = $urandom;
    bus.stall_disable        = 1'b1;
    bus.flush                = 1'b0;
  endtask

  // Advance one rising edge and let the reference model take the same step.
  task automatic clock_edge();
    logic        we_e, ret_e;
    logic [4:0]  rd_e;
    logic [31:0] data_e;
    we_e   = model_we();
    rd_e   = bus.instruction_MEMWB[11:7];
    data_e = model_wdata();
    ret_e  = bus.stall_disable && !bus.flush && (bus.instruction_MEMWB != 32'h0);
    @(posedge clk);
    if (rst_n) begin
      if (we_e) model_rf[rd_e] = data_e;
      if (ret_e) model_count = model_count + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = 5'(a);
      bus.rs2_addr = 5'(31 - a);
      #1;
      sb.push_back('{$sformatf("reset_rs1_x%0d", a), 32'h0});
      sb.push_back('{$sformatf("reset_rs2_x%0d", 31 - a), 32'h0});
      e = sb.pop_front(); vectors++;
      if (bus.rs1_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
      end
      e = sb.pop_front(); vectors++;
      if (bus.rs2_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs2_data, e.val);
      end
    end
    sb.push_back('{"reset_count", 32'h0});
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [9] = '{3'd0, 3'd4, 3'd1, 3'd0, 3'd0, 3'd5, 3'd5, 3'd2, 3'd3};
    logic [1:0]  off_t [9] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
    logic [31:0] want_t[9] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'hFFFFFF80,
                               32'h00000001, 32'h00007F01, 32'h000080FF, 32'h80FF7F01,
                               32'h80FF7F01};
    logic [31:0] pc;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, mk_instr(f3_t[i], 5'd5, 7'h03), {30'h0000_0400, off_t[i]}, 1'b1, 32'h80FF7F01);
      pc = bus.PC_MEMWB;
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd0;
      #1;
      sb.push_back('{$sformatf("load%0d_wb_data", i), want_t[i]});
      sb.push_back('{$sformatf("load%0d_wb_pc", i), pc});
      e = sb.pop_front(); vectors++;
      if (bus.wb_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.wb_data, e.val);
      end
      e = sb.pop_front(); vectors++;
      if (bus.wb_pc !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.wb_pc, e.val);
      end
      sb.push_back('{$sformatf("load%0d_x5", i), want_t[i]});
      clock_edge();
      bus.regWriteEnable_MEMWB = 1'b0;
      #1;
      e = sb.pop_front(); vectors++;
      if (bus.rs1_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
      end
    end
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd6, 7'h33), 32'hCAFEF00D, 1'b0, 32'h80FF7F01);
    #1;
    sb.push_back('{"alu_wb_data", 32'hCAFEF00D});
    e = sb.pop_front(); vectors++;
    if (bus.wb_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.wb_data, e.val);
    end
    clock_edge();
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd7, 7'h33), 32'h12345678, 1'b0, 32'h0);
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    #1;
    for (int phase = 0; phase < 2; phase++) begin
      sb.push_back('{$sformatf("bypass_p%0d_rs1", phase), 32'h12345678});
      sb.push_back('{$sformatf("bypass_p%0d_rs2", phase), 32'h12345678});
      e = sb.pop_front(); vectors++;
      if (bus.rs1_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
      end
      e = sb.pop_front(); vectors++;
      if (bus.rs2_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs2_data, e.val);
      end
      if (phase == 0) begin
        clock_edge();
        bus.regWriteEnable_MEMWB = 1'b0;
        bus.execute_rst_MEMWB    = 32'h0BAD0BAD;
        #1;
      end
    end
  endtask

  task automatic test_suppress();
    logic [31:0] c0;
    c0 = model_count;
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd0, 7'h33), 32'hDEADBEEF, 1'b0, 32'h0);
    #1;
    sb.push_back('{"rd0_wb_we", 32'h0});
    e = sb.pop_front(); vectors++;
    if ({31'h0, bus.wb_we} !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.wb_we, e.val);
    end
    clock_edge();
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd3, 7'h33), 32'hDEADBEEF, 1'b0, 32'h0);
    bus.flush = 1'b1;
    #1;
    sb.push_back('{"flush_wb_we", 32'h0});
    e = sb.pop_front(); vectors++;
    if ({31'h0, bus.wb_we} !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.wb_we, e.val);
    end
    clock_edge();
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd4, 7'h33), 32'hDEADBEEF, 1'b0, 32'h0);
    bus.stall_disable = 1'b0;
    clock_edge();
    bus.regWriteEnable_MEMWB = 1'b0;
    for (int a = 0; a < 5; a++) begin
      if (a == 1 || a == 2) continue;
      bus.rs1_addr = 5'(a);
      #1;
      sb.push_back('{$sformatf("suppress_x%0d", a), 32'h0});
      e = sb.pop_front(); vectors++;
      if (bus.rs1_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
      end
    end
    sb.push_back('{"suppress_count", c0 + 32'd1});
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    force dut.count_q = 32'hFFFFFFFE;
    #1;
    release dut.count_q;
    model_count = 32'hFFFFFFFE;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive(1'b0, mk_instr(3'd0, 5'd12, 7'h13), 32'h1, 1'b0, 32'h0);
      clock_edge();
    end
    sb.push_back('{"wrap_count", 32'h1});
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    clock_edge();
    sb.push_back('{"bubble_count", 32'h1});
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] rd, prev_rd;
    logic       memrd;
    prev_rd = 5'd7;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rd    = 5'($urandom_range(0, 31));
      memrd = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 3) != 0, mk_instr(3'($urandom_range(0, 7)), rd,
            memrd ? 7'h03 : 7'h33), $urandom, memrd, $urandom);
      bus.stall_disable = ($urandom_range(0, 7) != 0);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.rs1_addr      = prev_rd;
      bus.rs2_addr      = (n % 3 == 0) ? rd : 5'($urandom_range(0, 31));
      sb.push_back('{$sformatf("b2b%0d_rs1_x%0d", n, prev_rd), model_read(prev_rd)});
      sb.push_back('{$sformatf("b2b%0d_rs2_x%0d", n, bus.rs2_addr), model_read(bus.rs2_addr)});
      #1;
      e = sb.pop_front(); vectors++;
      if (bus.rs1_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
      end
      e = sb.pop_front(); vectors++;
      if (bus.rs2_data !== e.val) begin
        miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs2_data, e.val);
      end
      prev_rd = rd;
      clock_edge();
    end
    sb.push_back('{"b2b_count", model_count});
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, mk_instr(3'd0, 5'd9, 7'h33), 32'hA5A5A5A5, 1'b0, 32'h0);
    clock_edge();
    bus.regWriteEnable_MEMWB = 1'b0;
    bus.rs1_addr = 5'd9;
    #1;
    sb.push_back('{"pre_reset_x9", 32'hA5A5A5A5});
    e = sb.pop_front(); vectors++;
    if (bus.rs1_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int a = 0; a < 32; a++) model_rf[a] = 32'h0;
    model_count = 32'h0;
    #1;
    sb.push_back('{"async_x9", 32'h0});
    sb.push_back('{"async_count", 32'h0});
    e = sb.pop_front(); vectors++;
    if (bus.rs1_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
    end
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
    drive(1'b1, mk_instr(3'd0, 5'd10, 7'h33), 32'h00000055, 1'b0, 32'h0);
    bus.rs2_addr = 5'd10;
    #0.5;
    sb.push_back('{"reset_bypass_x10", 32'h00000055});
    e = sb.pop_front(); vectors++;
    if (bus.rs2_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs2_data, e.val);
    end
    clock_edge();
    bus.regWriteEnable_MEMWB = 1'b0;
    #1;
    sb.push_back('{"reset_nowrite_x10", 32'h0});
    sb.push_back('{"reset_nocount", 32'h0});
    e = sb.pop_front(); vectors++;
    if (bus.rs2_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs2_data, e.val);
    end
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, mk_instr(3'd0, 5'd11, 7'h33), 32'h00000011, 1'b0, 32'h0);
    clock_edge();
    bus.regWriteEnable_MEMWB = 1'b0;
    bus.rs1_addr = 5'd11;
    #1;
    sb.push_back('{"resume_x11", 32'h00000011});
    sb.push_back('{"resume_count", 32'h1});
    e = sb.pop_front(); vectors++;
    if (bus.rs1_data !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.rs1_data, e.val);
    end
    e = sb.pop_front(); vectors++;
    if (bus.retired_count !== e.val) begin
      miscompares++; $display("FAIL %s: got %h want %h", e.name, bus.retired_count, e.val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 32; a++) model_rf[a] = 32'h0;
    model_count = 32'h0;
    test_reset();
    test_loads();
    test_bypass();
    test_suppress();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
